spi_slave_regfile: RTL and testbench

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

---
 rtl/spi_slave_regfile.sv | 203 ++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI slave with a small register file.
// Frame: 1 R/W bit (1 = write), ADDR_WIDTH address bits, DATA_WIDTH data bits, all MSB first.
// All SPI pins are synchronised into clk; edges are detected on the synchronised sclk.
module spi_slave_regfile #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_NUM    = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs,
   input  logic mosi,
   output logic miso,
   output logic wr_done,
   output logic rd_done,
   output logic frame_err,
   output logic addr_err
);

   localparam int unsigned CMD_BITS = ADDR_WIDTH + 1;
   localparam int unsigned CNT_W    = $clog2(ADDR_WIDTH + DATA_WIDTH + 2);
   localparam int unsigned IDX_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam logic [ADDR_WIDTH:0] REG_NUM_W = (ADDR_WIDTH + 1)'(REG_NUM);

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StWdata,
      StRdata,
      StWaitCs
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH:0]     cmd_sr_q, cmd_sr_d;
   logic [DATA_WIDTH-1:0]   data_sr_q, data_sr_d;
   logic                    seen_rise_q, seen_rise_d;
   logic [DATA_WIDTH-1:0]   regs_q [REG_NUM];

   logic sclk_meta, sclk_s, sclk_prev;
   logic cs_meta, cs_s, cs_prev;
   logic mosi_meta, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic                  wr_en;
   logic                  wr_done_d, rd_done_d, frame_err_d, addr_err_d;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  addr_ok;
   logic [IDX_W-1:0]      idx;

   // Two-flop synchronisers plus one history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_meta <= 1'b0;
         sclk_s    <= 1'b0;
         sclk_prev <= 1'b0;
         cs_meta   <= 1'b0;
         cs_s      <= 1'b0;
         cs_prev   <= 1'b0;
         mosi_meta <= 1'b0;
         mosi_s    <= 1'b0;
      end else begin
         sclk_meta <= sclk;
         sclk_s    <= sclk_meta;
         sclk_prev <= sclk_s;
         cs_meta   <= cs;
         cs_s      <= cs_meta;
         cs_prev   <= cs_s;
         mosi_meta <= mosi;
         mosi_s    <= mosi_meta;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_rise   = cs_s & ~cs_prev;
   assign cs_fall   = ~cs_s & cs_prev;

   // The whole address field takes part in the range check.
   assign addr    = cmd_sr_q[ADDR_WIDTH-1:0];
   assign addr_ok = ({1'b0, addr} < REG_NUM_W);
   assign idx     = addr[IDX_W-1:0];

   // Frame FSM and datapath next-state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_sr_d    = cmd_sr_q;
      data_sr_d   = data_sr_q;
      seen_rise_d = seen_rise_q;
      wr_en       = 1'b0;
      wr_done_d   = 1'b0;
      rd_done_d   = 1'b0;
      frame_err_d = 1'b0;
      addr_err_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cs_rise) begin
               state_d  = StCmd;
               cnt_d    = '0;
               cmd_sr_d = '0;
            end
         end
         StCmd: begin
            if (cs_fall) begin
               frame_err_d = 1'b1;
               state_d     = StIdle;
            end else if (cnt_q == CNT_W'(CMD_BITS)) begin
               cnt_d       = '0;
               seen_rise_d = 1'b0;
               if (cmd_sr_q[ADDR_WIDTH]) begin
                  state_d   = StWdata;
                  data_sr_d = '0;
               end else begin
                  state_d    = StRdata;
                  data_sr_d  = addr_ok ? regs_q[idx] : '0;
                  addr_err_d = ~addr_ok;
               end
            end else if (sclk_rise) begin
               cmd_sr_d = {cmd_sr_q[ADDR_WIDTH-1:0], mosi_s};
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         StWdata: begin
            if (cs_fall) begin
               frame_err_d = 1'b1;
               state_d     = StIdle;
            end else if (cnt_q == CNT_W'(DATA_WIDTH)) begin
               wr_en      = addr_ok;
               wr_done_d  = addr_ok;
               addr_err_d = ~addr_ok;
               state_d    = StWaitCs;
            end else if (sclk_rise) begin
               data_sr_d = {data_sr_q[DATA_WIDTH-2:0], mosi_s};
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         StRdata: begin
            if (cs_fall) begin
               frame_err_d = 1'b1;
               state_d     = StIdle;
            end else if (cnt_q == CNT_W'(DATA_WIDTH)) begin
               rd_done_d = 1'b1;
               state_d   = StWaitCs;
            end else if (sclk_rise) begin
               cnt_d       = cnt_q + CNT_W'(1);
               seen_rise_d = 1'b1;
            end else if (sclk_fall && seen_rise_q) begin
               // The falling edge closing the last command bit arrives before any
               // data rising edge and must not consume the MSB.
               data_sr_d = {data_sr_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
         StWaitCs: begin
            if (cs_fall) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, shift registers and registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cmd_sr_q    <= '0;
         data_sr_q   <= '0;
         seen_rise_q <= 1'b0;
         wr_done     <= 1'b0;
         rd_done     <= 1'b0;
         frame_err   <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_sr_q    <= cmd_sr_d;
         data_sr_q   <= data_sr_d;
         seen_rise_q <= seen_rise_d;
         wr_done     <= wr_done_d;
         rd_done     <= rd_done_d;
         frame_err   <= frame_err_d;
         addr_err    <= addr_err_d;
      end
   end

   // Register file; written only in the commit cycle of a valid write frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(REG_NUM); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[idx] <= data_sr_q;
      end
   end

   // miso is driven only while a read is in progress.
   assign miso = (state_q == StRdata) ? data_sr_q[DATA_WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed frames then random frames
// against an array model of the register file.
module tb_spi_slave_regfile;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic cs = 1'b0;
   logic mosi = 1'b0;
   logic miso, wr_done, rd_done, frame_err, addr_err;

   int checks = 0;
   int errors = 0;
   int n_wr = 0, n_rd = 0, n_ferr = 0, n_aerr = 0;
   logic [31:0] ref_regs [16];

   spi_slave_regfile #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(32),
      .REG_NUM   (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .cs       (cs),
      .mosi     (mosi),
      .miso     (miso),
      .wr_done  (wr_done),
      .rd_done  (rd_done),
      .frame_err(frame_err),
      .addr_err (addr_err)
   );

   always #5 clk = ~clk;

   // Count high cycles of each status pulse.
   always @(posedge clk) begin
      if (wr_done)   n_wr   <= n_wr + 1;
      if (rd_done)   n_rd   <= n_rd + 1;
      if (frame_err) n_ferr <= n_ferr + 1;
      if (addr_err)  n_aerr <= n_aerr + 1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Master: 5 clk low / 5 clk high per bit. abort_n >= 0 drops cs after that many bits;
   // rst_at >= 0 pulses rst_n before that data bit.
   task automatic spi_frame(input bit rw, input logic [15:0] addr, input logic [31:0] wdata,
                            input int gap, input int abort_n, input int rst_at,
                            output logic [31:0] rdata);
      logic [48:0] bits;
      bits  = {rw, addr, wdata};
      rdata = '0;
      cs    = 1'b1;
      clks(4);
      for (int i = 0; i < 49; i++) begin
         if (i == abort_n) begin
            cs = 1'b0;
            clks(8);
            return;
         end
         if (i == 17) clks(gap);
         if (i >= 17 && (i - 17) == rst_at) begin
            rst_n = 1'b0;
            cs    = 1'b0;
            sclk  = 1'b0;
            mosi  = 1'b0;
            clks(2);
            check_eq("miso_in_reset", {31'b0, miso}, 32'h0);
            clks(2);
            rst_n = 1'b1;
            clks(6);
            return;
         end
         mosi = bits[48-i];
         clks(5);
         if (i >= 17) rdata = {rdata[30:0], miso};
         sclk = 1'b1;
         clks(5);
         sclk = 1'b0;
      end
      clks(4);
      cs   = 1'b0;
      mosi = 1'b0;
      clks(8);
   endtask

   // One frame checked against the model: read data and the number of each pulse.
   task automatic do_frame(input bit rw, input logic [15:0] addr, input logic [31:0] data,
                           input int gap, input int abort_n);
      int w0 = n_wr;
      int r0 = n_rd;
      int f0 = n_ferr;
      int a0 = n_aerr;
      bit valid = (addr < 16);
      bit done = (abort_n < 0);
      logic [31:0] exp_rd = valid ? ref_regs[addr[3:0]] : 32'h0;
      logic [31:0] got;
      int e_wr = (done && rw && valid) ? 1 : 0;
      int e_rd = (done && !rw) ? 1 : 0;
      int e_f  = done ? 0 : 1;
      int e_a  = (!valid && (done || (!rw && abort_n >= 17))) ? 1 : 0;
      spi_frame(rw, addr, data, gap, abort_n, -1, got);
      if (done && !rw) check_eq("read_data", got, exp_rd);
      if (e_wr == 1) ref_regs[addr[3:0]] = data;
      check_eq("wr_done_cnt",   32'(n_wr - w0),   32'(e_wr));
      check_eq("rd_done_cnt",   32'(n_rd - r0),   32'(e_rd));
      check_eq("frame_err_cnt", 32'(n_ferr - f0), 32'(e_f));
      check_eq("addr_err_cnt",  32'(n_aerr - a0), 32'(e_a));
   endtask

   initial begin
      logic [31:0] dummy;
      int w0, r0, f0, a0;
      int sel;
      logic [15:0] raddr;
      for (int i = 0; i < 16; i++) ref_regs[i] = 32'h0;

      clks(3);
      check_eq("reset_miso", {31'b0, miso}, 32'h0);
      check_eq("reset_pulses", {28'b0, wr_done, rd_done, frame_err, addr_err}, 32'h0);
      rst_n = 1'b1;
      clks(5);

      // Basic write then read with the long inter-phase gap.
      do_frame(1'b1, 16'h0003, 32'hA5A5_5A5A, 0, -1);
      do_frame(1'b0, 16'h0003, 32'h0, 50, -1);
      // Out-of-range addresses, including high address bits.
      do_frame(1'b1, 16'h0010, 32'hDEAD_BEEF, 0, -1);
      do_frame(1'b0, 16'h8003, 32'h0, 10, -1);
      do_frame(1'b0, 16'h0003, 32'h0, 0, -1);
      // Aborted write after 20 bits, then a full frame.
      do_frame(1'b1, 16'h0003, 32'h1111_2222, 0, 20);
      do_frame(1'b0, 16'h0003, 32'h0, 5, -1);
      // Back-to-back write/read of reg 0.
      do_frame(1'b1, 16'h0000, 32'h1234_5678, 0, -1);
      do_frame(1'b0, 16'h0000, 32'h0, 0, -1);
      do_frame(1'b1, 16'h000F, 32'hFFFF_0001, 3, -1);
      do_frame(1'b0, 16'h000F, 32'h0, 0, -1);

      // Reset in the middle of a read: no pulses, everything cleared.
      w0 = n_wr; r0 = n_rd; f0 = n_ferr; a0 = n_aerr;
      spi_frame(1'b0, 16'h0000, 32'h0, 0, -1, 10, dummy);
      check_eq("rst_pulses", 32'((n_wr - w0) + (n_rd - r0) + (n_ferr - f0) + (n_aerr - a0)),
               32'h0);
      check_eq("rst_miso", {31'b0, miso}, 32'h0);
      for (int i = 0; i < 16; i++) ref_regs[i] = 32'h0;
      for (int i = 0; i < 16; i++) do_frame(1'b0, 16'(i), 32'h0, 0, -1);

      // Random frames.
      for (int n = 0; n < 30; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)       raddr = 16'($urandom_range(0, 15));
         else if (sel == 7) raddr = 16'($urandom_range(16, 31));
         else               raddr = 16'($urandom_range(0, 65535)) | 16'h4000;
         do_frame(1'($urandom_range(0, 1)), raddr, $urandom, $urandom_range(0, 50),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 48)) : -1);
      end
      for (int i = 0; i < 16; i++) do_frame(1'b0, 16'(i), 32'h0, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
